// File: rtl/lb_share_pkg.sv
// Shared defaults and types for the two-master localbus sharer.
package lb_share_pkg;

  localparam int unsigned AW_DEF     = 24;
  localparam int unsigned DW_DEF     = 32;
  localparam int unsigned NLAT_DEF   = 8;
  localparam int unsigned STARVE_DEF = 255;
  localparam int unsigned WCNT_W     = 12;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  // One owner-pipeline stage: read pending plus which master issued it.
  typedef struct packed {
    logic   rdv;
    owner_e own;
  } pipe_ent_t;

endpackage

// File: rtl/lb_share2_if.sv
// Localbus sharer signal bundle: master A, sequencer B and the shared slave bus.
// The master modport is the sharer itself (it owns the slave bus); slave is its environment.
interface lb_share2_if #(
  parameter int unsigned aw = 24,
  parameter int unsigned dw = 32
) ();

  logic [aw-1:0] a_addr;
  logic          a_strobe;
  logic          a_rd;
  logic [dw-1:0] a_wdata;
  logic [dw-1:0] a_rdata;
  logic          a_rvalid;

  logic          b_req;
  logic [aw-1:0] b_addr;
  logic          b_rd;
  logic [dw-1:0] b_wdata;
  logic          b_grant;
  logic [dw-1:0] b_rdata;
  logic          b_rvalid;
  logic          b_starve;

  logic [aw-1:0] addr;
  logic          control_strobe;
  logic          control_rd;
  logic [dw-1:0] data_out;
  logic [dw-1:0] data_in;

  modport master (
    input  a_addr, a_strobe, a_rd, a_wdata,
    input  b_req, b_addr, b_rd, b_wdata,
    input  data_in,
    output a_rdata, a_rvalid,
    output b_grant, b_rdata, b_rvalid, b_starve,
    output addr, control_strobe, control_rd, data_out
  );

  modport slave (
    output a_addr, a_strobe, a_rd, a_wdata,
    output b_req, b_addr, b_rd, b_wdata,
    output data_in,
    input  a_rdata, a_rvalid,
    input  b_grant, b_rdata, b_rvalid, b_starve,
    input  addr, control_strobe, control_rd, data_out
  );

endinterface

// File: rtl/lb_owner_pipe.sv
// n_lat-deep {rdv, own} shift register that steers slave read returns to their issuer.
module lb_owner_pipe
  import lb_share_pkg::*;
#(
  parameter int unsigned n_lat = NLAT_DEF
) (
  input  logic      clk,
  input  logic      rst,
  input  pipe_ent_t ent_i,
  output pipe_ent_t tail_o
);

  logic [n_lat-1:0] rdv_q;
  logic [n_lat-1:0] own_q;

  // Reset drops any reads still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdv_q <= '0;
      own_q <= '0;
    end else begin
      rdv_q <= {rdv_q[n_lat-2:0], ent_i.rdv};
      own_q <= {own_q[n_lat-2:0], ent_i.own == OWN_B};
    end
  end

  always_comb begin
    tail_o.rdv = rdv_q[n_lat-1];
    tail_o.own = owner_e'(own_q[n_lat-1]);
  end

endmodule

// File: rtl/lb_share2.sv
// Two-master localbus sharer: A passes through with native timing, B fills A-idle cycles.
module lb_share2
  import lb_share_pkg::*;
#(
  parameter int unsigned aw         = AW_DEF,
  parameter int unsigned dw         = DW_DEF,
  parameter int unsigned n_lat      = NLAT_DEF,
  parameter int unsigned starve_max = STARVE_DEF
) (
  input logic         clk,
  input logic         rst,
  lb_share2_if.master bus
);

  logic              sel_b;
  logic [aw-1:0]     mux_addr;
  logic              mux_rd;
  logic [dw-1:0]     mux_wdata;
  logic              strobe;
  pipe_ent_t         ent_in;
  pipe_ent_t         ent_tail;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              b_starve_q, b_starve_d;

  assign sel_b  = bus.b_req & ~bus.a_strobe & ~rst;
  assign strobe = bus.a_strobe | sel_b;

  // Zero-latency bus mux; A fields also sit on the bus while idle.
  always_comb begin
    mux_addr  = bus.a_addr;
    mux_rd    = bus.a_rd;
    mux_wdata = bus.a_wdata;
    if (sel_b) begin
      mux_addr  = bus.b_addr;
      mux_rd    = bus.b_rd;
      mux_wdata = bus.b_wdata;
    end
  end

  assign bus.addr           = mux_addr;
  assign bus.control_strobe = strobe;
  assign bus.control_rd     = mux_rd;
  assign bus.data_out       = mux_wdata;
  assign bus.b_grant        = sel_b;

  always_comb begin
    ent_in.rdv = strobe & mux_rd;
    ent_in.own = sel_b ? OWN_B : OWN_A;
  end

  lb_owner_pipe #(.n_lat(n_lat)) u_owner_pipe (
    .clk    (clk),
    .rst    (rst),
    .ent_i  (ent_in),
    .tail_o (ent_tail)
  );

  assign bus.a_rvalid = ent_tail.rdv & (ent_tail.own == OWN_A);
  assign bus.b_rvalid = ent_tail.rdv & (ent_tail.own == OWN_B);
  assign bus.a_rdata  = bus.data_in;
  assign bus.b_rdata  = bus.data_in;

  // Saturating wait counter; starve flag is sticky until grant or withdraw.
  always_comb begin
    wait_cnt_d = '0;
    b_starve_d = b_starve_q;
    if (!bus.b_req || sel_b) begin
      b_starve_d = 1'b0;
    end else begin
      wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + WCNT_W'(1);
      if (wait_cnt_q >= WCNT_W'(starve_max)) begin
        b_starve_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      b_starve_q <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      b_starve_q <= b_starve_d;
    end
  end

  assign bus.b_starve = b_starve_q;

endmodule

// File: tb/tb_lb_share2.sv
// Scoreboard bench for lb_share2: stimulus queues expected bus/read events, a negedge monitor checks them.
module tb_lb_share2;

  localparam int unsigned AW   = 24;
  localparam int unsigned DW   = 32;
  localparam int unsigned NLAT = 8;
  localparam int unsigned SMAX = 255;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lb_share2_if #(.aw(AW), .dw(DW)) bus ();

  lb_share2 #(.aw(AW), .dw(DW), .n_lat(NLAT), .starve_max(SMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic          rd;
    logic [DW-1:0] wdata;
    logic          is_b;
  } bus_exp_t;

  typedef struct {
    int            cyc;
    logic          is_b;
    logic [DW-1:0] data;
  } rd_exp_t;

  bus_exp_t bus_q[$];
  rd_exp_t  rd_q[$];

  // Slave model: fixed-latency read data keyed by address.
  logic [DW-1:0] resp [NLAT];
  function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
    return (a == 24'h000010) ? 32'hDEADBEEF : {8'hA5, a};
  endfunction
  always @(posedge clk) begin
    resp[0] <= (bus.control_strobe & bus.control_rd) ? slave_data(bus.addr) : '0;
    for (int i = 1; i < int'(NLAT); i++) resp[i] <= resp[i-1];
  end
  assign bus.data_in = resp[NLAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.control_strobe === 1'b1) begin
      if (bus_q.size() == 0) begin
        chk("bus_unexpected", 64'(bus.addr), 64'hFFFF_FFFF);
      end else begin
        bus_exp_t e;
        e = bus_q.pop_front();
        chk("bus_cyc",   64'(cyc),            64'(e.cyc));
        chk("bus_addr",  64'(bus.addr),       64'(e.addr));
        chk("bus_rd",    64'(bus.control_rd), 64'(e.rd));
        chk("bus_grant", 64'(bus.b_grant),    64'(e.is_b));
        if (!e.rd) chk("bus_wdata", 64'(bus.data_out), 64'(e.wdata));
      end
    end else if (bus.b_grant === 1'b1) begin
      chk("grant_without_strobe", 64'(bus.b_grant), 64'd0);
    end
    if ((bus.a_rvalid | bus.b_rvalid) === 1'b1) begin
      chk("rvalid_exclusive", 64'(bus.a_rvalid & bus.b_rvalid), 64'd0);
      if (rd_q.size() == 0) begin
        chk("rvalid_unexpected", 64'({bus.a_rvalid, bus.b_rvalid}), 64'd0);
      end else begin
        rd_exp_t r;
        r = rd_q.pop_front();
        chk("rd_cyc",   64'(cyc),          64'(r.cyc));
        chk("rd_owner", 64'(bus.b_rvalid), 64'(r.is_b));
        chk("rd_data",  64'(r.is_b ? bus.b_rdata : bus.a_rdata), 64'(r.data));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.a_strobe = 1'b0;
    bus.b_req    = 1'b0;
  endtask

  task automatic a_txn(input logic [AW-1:0] a, input logic rd, input logic [DW-1:0] wd);
    bus.a_strobe = 1'b1;
    bus.a_addr   = a;
    bus.a_rd     = rd;
    bus.a_wdata  = wd;
    bus_q.push_back('{cyc, a, rd, wd, 1'b0});
  endtask

  task automatic b_set(input logic [AW-1:0] a, input logic rd, input logic [DW-1:0] wd);
    bus.b_req   = 1'b1;
    bus.b_addr  = a;
    bus.b_rd    = rd;
    bus.b_wdata = wd;
  endtask

  task automatic exp_b();
    bus_q.push_back('{cyc, bus.b_addr, bus.b_rd, bus.b_wdata, 1'b1});
  endtask

  task automatic exp_rd(input int lat, input logic is_b, input logic [DW-1:0] d);
    rd_q.push_back('{cyc + lat, is_b, d});
  endtask

  initial begin
    rst = 1'b1;
    bus.a_addr = '0; bus.a_strobe = 1'b0; bus.a_rd = 1'b0; bus.a_wdata = '0;
    bus.b_req  = 1'b0; bus.b_addr = '0; bus.b_rd = 1'b0; bus.b_wdata = '0;

    // Reset: no B grant, A still passes through.
    step();
    b_set(24'h000999, 1'b0, 32'h1);
    @(negedge clk);
    chk("rst_grant", 64'(bus.b_grant), 64'd0);
    chk("rst_strobe", 64'(bus.control_strobe), 64'd0);
    step();
    bus.b_req = 1'b0;
    a_txn(24'h000055, 1'b0, 32'h11);
    step();
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("rst_a_rvalid", 64'(bus.a_rvalid), 64'd0);
    chk("rst_b_rvalid", 64'(bus.b_rvalid), 64'd0);
    chk("rst_starve",   64'(bus.b_starve), 64'd0);
    chk("rst_wait_cnt", 64'(dut.wait_cnt_q), 64'd0);

    // A-only read.
    step();
    a_txn(24'h000010, 1'b1, 32'h0);
    exp_rd(8, 1'b0, 32'hDEADBEEF);
    step();
    idle();
    repeat (10) step();

    // B-only write, then back-to-back B write and read.
    b_set(24'h000123, 1'b0, 32'h5A);
    exp_b();
    @(negedge clk);
    chk("b_only_grant", 64'(bus.b_grant), 64'd1);
    step();
    idle();
    repeat (10) step();
    b_set(24'h000200, 1'b0, 32'h77);
    exp_b();
    step();
    b_set(24'h000201, 1'b1, 32'h0);
    exp_b();
    exp_rd(8, 1'b1, 32'hA5000201);
    @(negedge clk);
    chk("b2b_grant", 64'(bus.b_grant), 64'd1);
    step();
    idle();
    repeat (10) step();

    // Collision: A first, B one cycle later.
    a_txn(24'h000020, 1'b1, 32'h0);
    b_set(24'h000030, 1'b1, 32'h0);
    exp_rd(8, 1'b0, 32'hA5000020);
    @(negedge clk);
    chk("coll_grant_t", 64'(bus.b_grant), 64'd0);
    step();
    bus.a_strobe = 1'b0;
    exp_b();
    exp_rd(8, 1'b1, 32'hA5000030);
    @(negedge clk);
    chk("coll_grant_t1", 64'(bus.b_grant), 64'd1);
    step();
    idle();
    repeat (10) step();

    // Starvation under a 300-cycle A burst.
    b_set(24'h0003FF, 1'b0, 32'hCAFE);
    for (int k = 0; k < 300; k++) begin
      a_txn(24'h001000 + 24'(k), 1'b0, 32'(k));
      if (k == 254) begin
        @(negedge clk);
        chk("starve_k254", 64'(bus.b_starve), 64'd0);
      end
      if (k == 257) begin
        @(negedge clk);
        chk("starve_k257", 64'(bus.b_starve), 64'd1);
      end
      step();
    end
    bus.a_strobe = 1'b0;
    exp_b();
    @(negedge clk);
    chk("starve_grant", 64'(bus.b_grant), 64'd1);
    chk("starve_at_grant", 64'(bus.b_starve), 64'd1);
    step();
    b_set(24'h000400, 1'b0, 32'h44);
    a_txn(24'h002000, 1'b0, 32'h0);
    @(negedge clk);
    chk("starve_after_grant", 64'(bus.b_starve), 64'd0);
    step();
    bus.a_strobe = 1'b0;
    exp_b();
    step();
    idle();
    repeat (3) step();

    // Reset mid-flight: the granted B read must never return.
    b_set(24'h000500, 1'b1, 32'h0);
    exp_b();
    step();
    b_set(24'h000501, 1'b1, 32'h0);
    a_txn(24'h000600, 1'b0, 32'h6);
    step();
    a_txn(24'h000601, 1'b0, 32'h7);
    step();
    rst = 1'b1;
    a_txn(24'h000602, 1'b0, 32'h8);
    @(negedge clk);
    chk("midrst_grant", 64'(bus.b_grant), 64'd0);
    step();
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("midrst_a_rvalid", 64'(bus.a_rvalid), 64'd0);
    chk("midrst_b_rvalid", 64'(bus.b_rvalid), 64'd0);
    chk("midrst_starve",   64'(bus.b_starve), 64'd0);
    chk("midrst_wait_cnt", 64'(dut.wait_cnt_q), 64'd0);
    repeat (10) step();

    // Withdraw: B requests under an A burst then gives up.
    for (int k = 0; k < 5; k++) begin
      a_txn(24'h000700 + 24'(k), 1'b0, 32'(k));
      if (k < 3) b_set(24'h000777, 1'b0, 32'h9);
      else bus.b_req = 1'b0;
      @(negedge clk);
      chk("withdraw_grant", 64'(bus.b_grant), 64'd0);
      step();
    end
    idle();
    @(negedge clk);
    chk("withdraw_wait_cnt", 64'(dut.wait_cnt_q), 64'd0);

    repeat (12) step();
    chk("bus_q_drained", 64'(bus_q.size()), 64'd0);
    chk("rd_q_drained",  64'(rd_q.size()),  64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
